// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the fifo_sync write-port arbiter.
//   arb_state_e : arbiter FSM state (ARB = open for round-robin, HOLD = burst owner locked)
//   STAT_W      : width of each per-requester beat counter
//   idw()       : index width for a requester count (at least 1 bit)
//   wrap_inc()  : increment an index modulo n (works for non-power-of-2 n)
package fifo_arb_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    HOLD = 1'b1
  } arb_state_e;

  localparam int STAT_W = 16;

  function automatic int idw(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
// Finds the first asserted bit of valid at or after rr_ptr, wrapping modulo N_REQ.
// Ports:
//   valid  in  N_REQ  request vector
//   rr_ptr in  IDW    starting index (always < N_REQ)
//   sel    out IDW    chosen index (0 when nothing found)
//   found  out 1      some request was valid
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDW   = idw(N_REQ)
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [IDW-1:0]   rr_ptr,
  output logic [IDW-1:0]   sel,
  output logic             found
);

  logic [IDW-1:0]   cand_idx [N_REQ];
  logic [N_REQ-1:0] cand_valid;

  // Candidate gi is the requester gi positions after rr_ptr. The sum is one bit
  // wider so a single conditional subtract handles wrap for any N_REQ.
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
      logic [IDW:0] sum;
      assign sum            = {1'b0, rr_ptr} + (IDW+1)'(gi);
      assign cand_idx[gi]   = (sum >= (IDW+1)'(N_REQ)) ? IDW'(sum - (IDW+1)'(N_REQ))
                                                       : sum[IDW-1:0];
      assign cand_valid[gi] = valid[cand_idx[gi]];
    end
  endgenerate

  // Scan from the far end so the candidate closest to rr_ptr wins.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (cand_valid[k]) begin
        sel   = cand_idx[k];
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one fifo_sync write port among
// N_REQ valid/ready producers, with bursts that keep the grant until the last
// beat or MAX_BURST beats.
// Optional feature: define FIFO_ARB_STATS_EN to add saturating per-requester
// accepted-beat counters on beat_cnt.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   req_valid     per-requester beat present
//   req_data      packed beats, requester i at [i*DW +: DW]
//   req_last      per-requester last-beat flag
//   req_ready     one-hot or zero; combinational
//   fifo_full     fifo_sync full flag
//   fifo_write    fifo_sync write strobe (= any valid&ready)
//   fifo_data_in  selected beat, 0 when not writing
//   grant_id      current/last owner index (registered)
//   busy          1 while a burst holds the grant (registered)
//   beat_cnt      [FIFO_ARB_STATS_EN] N_REQ x 16-bit accepted-beat counters
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int N_REQ     = 4,
  parameter  int DW        = 16,
  parameter  int MAX_BURST = 4,
  localparam int IDW       = idw(N_REQ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ*DW-1:0] req_data,
  input  logic [N_REQ-1:0]    req_last,
  output logic [N_REQ-1:0]    req_ready,
  input  logic                fifo_full,
  output logic                fifo_write,
  output logic [DW-1:0]       fifo_data_in,
  output logic [IDW-1:0]      grant_id,
  output logic                busy
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [N_REQ*STAT_W-1:0] beat_cnt
`endif
);

  arb_state_e     state_reg;
  logic [IDW-1:0] rr_ptr_reg;
  logic [IDW-1:0] grant_id_reg;
  logic [7:0]     burst_cnt_reg;
  logic           busy_reg;

  logic [IDW-1:0]   pick_sel;
  logic             pick_found;
  logic [IDW-1:0]   sel_idx;
  logic [N_REQ-1:0] ready_vec;
  logic             accept;
  logic             burst_end;
  logic [IDW-1:0]   rr_ptr_next;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_rr_pick (
    .valid  (req_valid),
    .rr_ptr (rr_ptr_reg),
    .sel    (pick_sel),
    .found  (pick_found)
  );

  // Ready is raised only toward a requester whose beat will be taken this
  // cycle, so req_ready doubles as the accept vector.
  always_comb begin
    ready_vec = '0;
    sel_idx   = (state_reg == HOLD) ? grant_id_reg : pick_sel;
    if (!rst && !fifo_full) begin
      if (state_reg == ARB) begin
        if (pick_found) ready_vec[pick_sel] = 1'b1;
      end else if (req_valid[grant_id_reg]) begin
        ready_vec[grant_id_reg] = 1'b1;
      end
    end
  end

  assign accept       = |(req_valid & ready_vec);
  assign req_ready    = ready_vec;
  assign fifo_write   = accept;
  assign fifo_data_in = accept ? req_data[sel_idx*DW +: DW] : '0;
  assign grant_id     = grant_id_reg;
  assign busy         = busy_reg;

  // The first beat of a burst is taken in ARB, so in ARB only MAX_BURST==1 ends it.
  assign burst_end   = req_last[sel_idx] ||
                       ((state_reg == ARB) ? (MAX_BURST == 1)
                                           : (({1'b0, burst_cnt_reg} + 9'd1) == 9'(MAX_BURST)));
  assign rr_ptr_next = IDW'(wrap_inc(int'(sel_idx), N_REQ));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ARB;
      rr_ptr_reg    <= '0;
      grant_id_reg  <= '0;
      burst_cnt_reg <= '0;
      busy_reg      <= 1'b0;
    end else if (accept) begin
      grant_id_reg <= sel_idx;
      if (burst_end) begin
        state_reg     <= ARB;
        busy_reg      <= 1'b0;
        burst_cnt_reg <= '0;
        rr_ptr_reg    <= rr_ptr_next;
      end else begin
        state_reg     <= HOLD;
        busy_reg      <= 1'b1;
        burst_cnt_reg <= (state_reg == ARB) ? 8'd1 : burst_cnt_reg + 8'd1;
      end
    end
  end

`ifdef FIFO_ARB_STATS_EN
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_stat
      logic [STAT_W-1:0] stat_cnt_reg;
      always_ff @(posedge clk) begin
        if (rst) begin
          stat_cnt_reg <= '0;
        end else if (accept && (sel_idx == IDW'(gi)) && (stat_cnt_reg != '1)) begin
          stat_cnt_reg <= stat_cnt_reg + 1'b1;
        end
      end
      assign beat_cnt[gi*STAT_W +: STAT_W] = stat_cnt_reg;
    end
  endgenerate
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

  localparam int N   = 4;
  localparam int DW  = 16;
  localparam int MAXB = 4;

  typedef struct packed {
    logic          l;
    logic [DW-1:0] d;
  } beat_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    req_last = '0;
  logic [N-1:0]    req_ready;
  logic            fifo_full = 1'b0;
  logic            fifo_write;
  logic [DW-1:0]   fifo_data_in;
  logic [1:0]      grant_id;
  logic            busy;
`ifdef FIFO_ARB_STATS_EN
  logic [N*16-1:0] beat_cnt;
`endif

  fifo_wr_arbiter #(.N_REQ(N), .DW(DW), .MAX_BURST(MAXB)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .fifo_full    (fifo_full),
    .fifo_write   (fifo_write),
    .fifo_data_in (fifo_data_in),
    .grant_id     (grant_id),
    .busy         (busy)
`ifdef FIFO_ARB_STATS_EN
    ,
    .beat_cnt     (beat_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  beat_t         q [N][$];
  logic [DW-1:0] wr_log [$];
  logic [N-1:0]  acc_seen = '0;

  // Behavioural model: owner<0 means the grant is open for round-robin.
  int m_owner = -1;
  int m_beats = 0;
  int m_ptr   = 0;
  int m_gid   = 0;
  bit m_init  = 0;
  int m_stat [N];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Compare process: outputs are checked mid-cycle against the model, then the
  // model is advanced by the transfer that the next posedge will commit.
  always @(negedge clk) begin
    int           e_sel;
    logic [N-1:0] e_ready;
    logic [DW-1:0] e_data;
    acc_seen = req_valid & req_ready;
    if (fifo_write) begin
      wr_log.push_back(fifo_data_in);
      $display("t=%0t write data=%h grant_src=%b", $time, fifo_data_in, req_ready);
    end
    if (rst) begin
      chk("rst_ready", 64'(req_ready), 64'd0);
      chk("rst_write", 64'(fifo_write), 64'd0);
      if (m_init) begin
        chk("rst_gid", 64'(grant_id), 64'(m_gid));
        chk("rst_busy", 64'(busy), 64'(m_owner >= 0));
      end
      m_owner = -1; m_beats = 0; m_ptr = 0; m_gid = 0; m_init = 1;
      for (int i = 0; i < N; i++) m_stat[i] = 0;
    end else if (m_init) begin
      e_sel = -1;
      if (!fifo_full) begin
        if (m_owner < 0) begin
          for (int k = 0; k < N; k++)
            if (e_sel < 0 && req_valid[(m_ptr + k) % N]) e_sel = (m_ptr + k) % N;
        end else if (req_valid[m_owner]) begin
          e_sel = m_owner;
        end
      end
      e_ready = '0;
      e_data  = '0;
      if (e_sel >= 0) begin
        e_ready[e_sel] = 1'b1;
        e_data = req_data[e_sel*DW +: DW];
      end
      chk("ready", 64'(req_ready), 64'(e_ready));
      chk("write", 64'(fifo_write), 64'(e_sel >= 0));
      chk("data", 64'(fifo_data_in), 64'(e_data));
      chk("grant_id", 64'(grant_id), 64'(m_gid));
      chk("busy", 64'(busy), 64'(m_owner >= 0));
`ifdef FIFO_ARB_STATS_EN
      for (int i = 0; i < N; i++) chk("beat_cnt", 64'(beat_cnt[i*16 +: 16]), 64'(m_stat[i]));
`endif
      if (e_sel >= 0) begin
        int nb;
        nb = (m_owner < 0) ? 1 : m_beats + 1;
        m_gid = e_sel;
        if (m_stat[e_sel] < 65535) m_stat[e_sel]++;
        if (req_last[e_sel] || nb == MAXB) begin
          m_owner = -1; m_beats = 0; m_ptr = (e_sel + 1) % N;
        end else begin
          m_owner = e_sel; m_beats = nb;
        end
      end
    end
  end

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (q[i].size() > 0) begin
        req_valid[i] = 1'b1;
        req_data[i*DW +: DW] = q[i][0].d;
        req_last[i] = q[i][0].l;
      end else begin
        req_valid[i] = 1'b0;
        req_data[i*DW +: DW] = '0;
        req_last[i] = 1'b0;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (acc_seen[i] && q[i].size() > 0) void'(q[i].pop_front());
    drive();
  endtask

  task automatic run_idle(input int maxc);
    int n = 0;
    while ((q[0].size() + q[1].size() + q[2].size() + q[3].size()) > 0 && n < maxc) begin
      cycle();
      n++;
    end
    total++;
    if (n >= maxc) begin
      bad++;
      $display("FAIL idle_timeout: got %0d cycles required under %0d", n, maxc);
    end
  endtask

  task automatic push(input int r, input logic [DW-1:0] d, input logic l);
    beat_t b;
    b.d = d;
    b.l = l;
    q[r].push_back(b);
  endtask

  task automatic check_log(input string name, input logic [DW-1:0] exp_q [$]);
    chk({name, "_len"}, 64'(wr_log.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < wr_log.size()) chk({name, "_beat"}, 64'(wr_log[i]), 64'(exp_q[i]));
    end
    wr_log.delete();
  endtask

  initial begin
    logic [DW-1:0] exp_q [$];

    // Reset with every requester valid, then round-robin with pointer wrap.
    for (int i = 0; i < N; i++) push(i, 16'h10 + 16'(i), 1'b1);
    push(0, 16'h10, 1'b1);
    drive();
    for (int c = 0; c < 3; c++) begin
      cycle();
      chk("reset_write", 64'(fifo_write), 64'd0);
      chk("reset_ready", 64'(req_ready), 64'd0);
    end
    chk("reset_gid", 64'(grant_id), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    run_idle(50);
    exp_q = '{16'h10, 16'h11, 16'h12, 16'h13, 16'h10};
    check_log("rr", exp_q);

    // Burst from req1 holds the grant against req0 and req2.
    push(1, 16'h20, 1'b0); push(1, 16'h21, 1'b0); push(1, 16'h22, 1'b1);
    push(0, 16'h30, 1'b1);
    push(2, 16'h32, 1'b1);
    run_idle(50);
    exp_q = '{16'h20, 16'h21, 16'h22, 16'h32, 16'h30};
    check_log("burst", exp_q);

    // Park pointer at req0, then a 6-beat burst is cut at MAX_BURST.
    push(3, 16'h3F, 1'b1);
    run_idle(20);
    wr_log.delete();
    for (int i = 0; i < 6; i++) push(0, 16'h40 + 16'(i), (i == 5));
    push(1, 16'h50, 1'b1);
    run_idle(50);
    exp_q = '{16'h40, 16'h41, 16'h42, 16'h43, 16'h50, 16'h44, 16'h45};
    check_log("maxburst", exp_q);

    // FIFO full mid-burst: stall, then resume with no loss or duplicate.
    for (int i = 0; i < 4; i++) push(2, 16'h60 + 16'(i), (i == 3));
    cycle();
    cycle();
    fifo_full = 1'b1;
    #1;
    chk("full_write", 64'(fifo_write), 64'd0);
    chk("full_ready", 64'(req_ready), 64'd0);
    chk("full_busy", 64'(busy), 64'd1);
    for (int c = 0; c < 3; c++) cycle();
    fifo_full = 1'b0;
    run_idle(50);
    exp_q = '{16'h60, 16'h61, 16'h62, 16'h63};
    check_log("full", exp_q);

    // Reset during req3's second beat: burst abandoned, pointer back to 0.
    for (int i = 0; i < 4; i++) push(3, 16'h70 + 16'(i), (i == 3));
    push(0, 16'h80, 1'b1);
    push(1, 16'h51, 1'b1);
    cycle();
    cycle();
    chk("pre_rst_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    chk("post_rst_busy", 64'(busy), 64'd0);
    chk("post_rst_gid", 64'(grant_id), 64'd0);
`ifdef FIFO_ARB_STATS_EN
    chk("post_rst_stats", 64'(beat_cnt), 64'd0);
`endif
    run_idle(50);
    exp_q = '{16'h70, 16'h80, 16'h51, 16'h71, 16'h72, 16'h73};
    check_log("rst_hold", exp_q);
    cycle();
`ifdef FIFO_ARB_STATS_EN
    chk("stats0", 64'(beat_cnt[0*16 +: 16]), 64'd1);
    chk("stats1", 64'(beat_cnt[1*16 +: 16]), 64'd1);
    chk("stats2", 64'(beat_cnt[2*16 +: 16]), 64'd0);
    chk("stats3", 64'(beat_cnt[3*16 +: 16]), 64'd3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
